// File: rtl/ps2_famicom_pad.sv
// PS/2 keyboard plus joystick merged into an 8-button pad state, which is
// serialised to a Famicom-style console via an asynchronous latch and pulse.

module ps2_famicom_pad_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise
);
    logic s1, s2, prev;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~prev;
endmodule

module ps2_famicom_pad #(
    parameter bit ACTIVE_LOW_DATA = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  joy,
    input  logic        famicom_latch,
    input  logic        famicom_pulse,
    output logic        famicom_data,
    output logic [7:0]  pad_state
);
    localparam int NUM_LINES = 2;
    localparam int PAD_W     = 8;

    typedef struct packed {
        logic       toggle;
        logic       make;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    key_evt_t             key;
    logic                 toggle_q;
    logic                 key_event;
    logic [PAD_W-1:0]     key_sel;
    logic [PAD_W-1:0]     key_state, key_state_next;
    logic [PAD_W-1:0]     shreg, shreg_next;
    logic [NUM_LINES-1:0] line_in, line_sync, line_rise;
    logic                 latch_sync, pulse_rise;
    logic                 latch_rise_unused;

    assign key       = key_evt_t'(ps2_key);
    assign key_event = key.toggle ^ toggle_q;

    // Line 0 is the latch, line 1 the pulse.
    assign line_in = {famicom_pulse, famicom_latch};

    generate
        for (genvar i = 0; i < NUM_LINES; i++) begin : g_sync
            ps2_famicom_pad_sync u_sync (
                .clk_sys (clk_sys),
                .reset   (reset),
                .din     (line_in[i]),
                .sync    (line_sync[i]),
                .rise    (line_rise[i])
            );
        end
    endgenerate

    assign latch_sync        = line_sync[0];
    assign pulse_rise        = line_rise[1];
    assign latch_rise_unused = line_rise[0];

    // The ext flag is part of the match, so {0,74} is not Right.
    always_comb begin
        key_sel = '0;
        case ({key.ext, key.code})
            9'h01C:  key_sel[0] = 1'b1;
            9'h032:  key_sel[1] = 1'b1;
            9'h00D:  key_sel[2] = 1'b1;
            9'h05A:  key_sel[3] = 1'b1;
            9'h175:  key_sel[4] = 1'b1;
            9'h172:  key_sel[5] = 1'b1;
            9'h16B:  key_sel[6] = 1'b1;
            9'h174:  key_sel[7] = 1'b1;
            default: key_sel    = '0;
        endcase
    end

    always_comb begin
        key_state_next = key_state;
        for (int i = 0; i < PAD_W; i++)
            if (key_event && key_sel[i])
                key_state_next[i] = key.make;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            toggle_q  <= key.toggle;
            key_state <= '0;
            pad_state <= '0;
        end else begin
            toggle_q  <= key.toggle;
            key_state <= key_state_next;
            pad_state <= key_state | joy;
        end
    end

    // Load has priority over a coincident pulse edge.
    always_comb begin
        shreg_next = shreg;
        if (latch_sync)
            shreg_next = pad_state;
        else if (pulse_rise)
            shreg_next = {1'b0, shreg[PAD_W-1:1]};
    end

    // Output flop takes the next register value so latency is 3 edges.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shreg        <= '0;
            famicom_data <= ACTIVE_LOW_DATA;
        end else begin
            shreg        <= shreg_next;
            famicom_data <= shreg_next[0] ^ ACTIVE_LOW_DATA;
        end
    end
endmodule

// File: tb/tb_ps2_famicom_pad.sv
// Randomised and directed checks of ps2_famicom_pad against a behavioural
// model of key mapping, pad merging and serial readout.

module tb_ps2_famicom_pad;
    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic [7:0]  joy;
    logic        famicom_latch;
    logic        famicom_pulse;
    logic        famicom_data;
    logic [7:0]  pad_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_keys;
    logic [8:0] keymap [8] = '{9'h01C, 9'h032, 9'h00D, 9'h05A,
                               9'h175, 9'h172, 9'h16B, 9'h174};
    logic [8:0] pool [12]  = '{9'h01C, 9'h032, 9'h00D, 9'h05A,
                               9'h175, 9'h172, 9'h16B, 9'h174,
                               9'h029, 9'h074, 9'h11C, 9'h15A};

    ps2_famicom_pad dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .joy           (joy),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data),
        .pad_state     (pad_state)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    function automatic logic exp_serial(input logic [7:0] pad, input int i);
        logic pressed;
        pressed = (i < 8) ? pad[i] : 1'b0;
        return ~pressed;
    endfunction

    task automatic send_key(input logic ext, input logic [7:0] code, input logic make);
        logic [8:0] kc;
        ps2_key = {~ps2_key[10], make, ext, code};
        kc = {ext, code};
        for (int k = 0; k < 8; k++)
            if (keymap[k] == kc) model_keys[k] = make;
        tick(1);
    endtask

    task automatic pulse_once();
        famicom_pulse = 1'b1;
        tick(3);
        famicom_pulse = 1'b0;
        tick(3);
    endtask

    task automatic read_serial(input int n, output logic [15:0] bits);
        bits = '0;
        famicom_latch = 1'b1;
        tick(3);
        bits[0] = famicom_data;
        famicom_latch = 1'b0;
        tick(3);
        for (int i = 1; i < n; i++) begin
            famicom_pulse = 1'b1;
            tick(3);
            bits[i] = famicom_data;
            famicom_pulse = 1'b0;
            tick(3);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if (famicom_data !== 1'b1) begin
            errors++; $display("FAIL reset_data got=%b exp=1", famicom_data);
        end
        checks++;
        if (pad_state !== 8'h00) begin
            errors++; $display("FAIL reset_pad got=%h exp=00", pad_state);
        end
        reset = 1'b0;
        model_keys = '0;
        tick(2);
        checks++;
        if (famicom_data !== 1'b1 || pad_state !== 8'h00) begin
            errors++; $display("FAIL post_reset data=%b pad=%h exp 1/00", famicom_data, pad_state);
        end
    endtask

    task automatic test_single_a();
        logic [15:0] bits;
        send_key(1'b0, 8'h1C, 1'b1);
        tick(2);
        checks++;
        if (pad_state !== 8'h01) begin
            errors++; $display("FAIL a_pad got=%h exp=01", pad_state);
        end
        read_serial(8, bits);
        checks++;
        if (bits[7:0] !== 8'b1111_1110) begin
            errors++; $display("FAIL a_serial got=%b exp=11111110", bits[7:0]);
        end
        send_key(1'b0, 8'h1C, 1'b0);
        tick(2);
    endtask

    task automatic test_merge_joy();
        logic [15:0] bits;
        logic [9:0]  exp;
        send_key(1'b1, 8'h74, 1'b1);
        send_key(1'b0, 8'h5A, 1'b1);
        joy = 8'h02;
        tick(2);
        checks++;
        if (pad_state !== 8'h8A) begin
            errors++; $display("FAIL merge_pad got=%h exp=8A", pad_state);
        end
        read_serial(10, bits);
        for (int i = 0; i < 10; i++) exp[i] = exp_serial(model_keys | joy, i);
        checks++;
        if (bits[9:0] !== exp || exp !== 10'b11_0111_0101) begin
            errors++; $display("FAIL merge_serial got=%b exp=%b", bits[9:0], exp);
        end
        send_key(1'b1, 8'h74, 1'b0);
        send_key(1'b0, 8'h5A, 1'b0);
        joy = 8'h00;
        tick(2);
    endtask

    task automatic test_unmapped();
        send_key(1'b0, 8'h74, 1'b1);
        send_key(1'b0, 8'h29, 1'b1);
        send_key(1'b1, 8'h75, 1'b0);
        tick(2);
        checks++;
        if (pad_state !== 8'h00) begin
            errors++; $display("FAIL unmapped_pad got=%h exp=00", pad_state);
        end
        send_key(1'b0, 8'h32, 1'b1);
        send_key(1'b0, 8'h32, 1'b1);
        tick(2);
        checks++;
        if (pad_state !== 8'h02) begin
            errors++; $display("FAIL repeat_make got=%h exp=02", pad_state);
        end
        send_key(1'b0, 8'h32, 1'b0);
        tick(2);
        checks++;
        if (pad_state !== 8'h00) begin
            errors++; $display("FAIL break_b got=%h exp=00", pad_state);
        end
    endtask

    task automatic test_random();
        logic [15:0] bits;
        logic [9:0]  exp;
        logic [8:0]  kc;
        for (int it = 0; it < 10; it++) begin
            for (int e = 0; e < int'($urandom_range(1, 4)); e++) begin
                kc = pool[$urandom_range(0, 11)];
                send_key(kc[8], kc[7:0], 1'($urandom));
            end
            joy = 8'($urandom);
            tick(2);
            checks++;
            if (pad_state !== (model_keys | joy)) begin
                errors++; $display("FAIL rand_pad it=%0d got=%h exp=%h", it, pad_state, model_keys | joy);
            end
            read_serial(10, bits);
            for (int i = 0; i < 10; i++) exp[i] = exp_serial(model_keys | joy, i);
            checks++;
            if (bits[9:0] !== exp) begin
                errors++; $display("FAIL rand_serial it=%0d got=%b exp=%b", it, bits[9:0], exp);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] pad;
        send_key(1'b0, 8'h1C, 1'b1);
        joy = 8'h00;
        tick(2);
        repeat (9) pulse_once();
        checks++;
        if (famicom_data !== 1'b1) begin
            errors++; $display("FAIL drained got=%b exp=1", famicom_data);
        end
        pad = model_keys | joy;
        famicom_latch = 1'b1;
        tick(2);
        checks++;
        if (famicom_data !== 1'b1) begin
            errors++; $display("FAIL latch_early got=%b exp=1", famicom_data);
        end
        tick(1);
        checks++;
        if (famicom_data !== exp_serial(pad, 0)) begin
            errors++; $display("FAIL latch_3edge got=%b exp=%b", famicom_data, exp_serial(pad, 0));
        end
        pulse_once();
        checks++;
        if (famicom_data !== exp_serial(pad, 0)) begin
            errors++; $display("FAIL pulse_under_latch got=%b exp=%b", famicom_data, exp_serial(pad, 0));
        end
        famicom_latch = 1'b0;
        tick(3);
        famicom_pulse = 1'b1;
        tick(2);
        checks++;
        if (famicom_data !== exp_serial(pad, 0)) begin
            errors++; $display("FAIL pulse_early got=%b exp=%b", famicom_data, exp_serial(pad, 0));
        end
        tick(1);
        checks++;
        if (famicom_data !== exp_serial(pad, 1)) begin
            errors++; $display("FAIL pulse_3edge got=%b exp=%b", famicom_data, exp_serial(pad, 1));
        end
        famicom_pulse = 1'b0;
        tick(3);
        pulse_once();
        pulse_once();
        famicom_latch = 1'b1;
        tick(3);
        checks++;
        if (famicom_data !== exp_serial(pad, 0)) begin
            errors++; $display("FAIL relatch got=%b exp=%b", famicom_data, exp_serial(pad, 0));
        end
        famicom_latch = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid();
        logic [15:0] bits;
        logic [7:0]  exp;
        if (ps2_key[10] === 1'b1) send_key(1'b0, 8'h29, 1'b1);
        send_key(1'b0, 8'h1C, 1'b1);
        joy = 8'h00;
        tick(2);
        famicom_latch = 1'b1;
        tick(3);
        famicom_latch = 1'b0;
        tick(3);
        repeat (4) pulse_once();
        reset = 1'b1;
        tick(2);
        checks++;
        if (famicom_data !== 1'b1 || pad_state !== 8'h00) begin
            errors++; $display("FAIL mid_reset data=%b pad=%h exp 1/00", famicom_data, pad_state);
        end
        reset = 1'b0;
        model_keys = '0;
        tick(3);
        checks++;
        if (pad_state !== 8'h00) begin
            errors++; $display("FAIL no_spurious got=%h exp=00", pad_state);
        end
        joy = 8'($urandom_range(1, 255));
        tick(2);
        read_serial(8, bits);
        for (int i = 0; i < 8; i++) exp[i] = exp_serial(joy, i);
        checks++;
        if (bits[7:0] !== exp) begin
            errors++; $display("FAIL fresh_latch got=%b exp=%b", bits[7:0], exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        ps2_key       = '0;
        joy           = '0;
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;
        model_keys    = '0;
        test_reset();
        test_single_a();
        test_merge_joy();
        test_unmapped();
        test_random();
        test_latency();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_famicom_pad.md
PS2_FAMICOM_PAD -- requirements
Module: ps2_famicom_pad

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW_DATA, default 1, meaning famicom_data is 0 for a pressed button when 1 and is 1 for a pressed button when 0.
REQ-002 The block SHALL have port clk_sys, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port ps2_key, input, 11 bits: [10] toggles once per key event, [9] 1=make/0=break, [8] extended (E0) flag, [7:0] set-2 scancode.
REQ-005 The block SHALL have port joy, input, 8 bits: active-high buttons in pad order.
REQ-006 The block SHALL have port famicom_latch, input, 1 bit: asynchronous pad latch from the console.
REQ-007 The block SHALL have port famicom_pulse, input, 1 bit: asynchronous pad clock from the console.
REQ-008 The block SHALL have port famicom_data, output, 1 bit: serial button data to the console.
REQ-009 The block SHALL have port pad_state, output, 8 bits: current merged pressed state, active-high, in pad order, for status and debug.

Function
REQ-010 Pad bit order SHALL be: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-011 The key map SHALL be, as {ext,code}:
- A = {0,1C}
- B = {0,32}
- Select = {0,0D}
- Start = {0,5A}
- Up = {1,75}
- Down = {1,72}
- Left = {1,6B}
- Right = {1,74}
- An ext flag mismatch means no match.
REQ-012 A key event SHALL be detected when ps2_key[10] differs from the registered copy of ps2_key[10]; the copy updates every cycle.
REQ-013 On a key event with a mapped code, the key_state bit SHALL be set to ps2_key[9] at the same edge; unmapped codes SHALL change nothing.
REQ-014 Repeated make events for a held key SHALL leave its bit at 1; a break for a key that is not held SHALL leave its bit at 0.
REQ-015 pad_state SHALL be key_state OR joy, registered, with 1-cycle latency.
REQ-016 famicom_latch and famicom_pulse SHALL each pass through a 2-flop synchroniser followed by a previous-value flop; a rising edge is sync=1 and prev=0.
REQ-017 While the synchronised latch is 1, the 8-bit shift register SHALL parallel-load pad_state on every cycle.
REQ-018 On a synchronised pulse rising edge while the synchronised latch is 0, the register SHALL shift right by one and fill with 0 (released).
- After 8 pulses, all released is reported.
- Further pulses keep reporting released.
REQ-019 If a pulse edge and latch=1 coincide, the load SHALL win and no shift occurs.
REQ-020 famicom_data SHALL be register bit0, inverted when ACTIVE_LOW_DATA=1, driven from a flop.
REQ-021 Latency SHALL be 3 clk_sys rising edges from the input transition to the famicom_data change, for both the latch rise and the pulse rise.
REQ-022 A latch asserted mid-sequence SHALL restart the sequence at bit0 (A) with no error state.

Reset
REQ-023 On reset, the following SHALL be cleared to 0:
- key_state
- the shift register
- pad_state
- the synchroniser and prev flops
REQ-024 On reset, famicom_data SHALL be 1 when ACTIVE_LOW_DATA=1 and 0 otherwise.
REQ-025 On reset, the ps2_key[10] copy SHALL load the current ps2_key[10] so that no spurious event follows reset.
REQ-026 Reset asserted mid-sequence SHALL abort the shift, and the next latch SHALL start fresh.

Verification
REQ-027 Toggle ps2_key with {1,1,0x1C}, then latch and 8 pulses -> famicom_data (active-low) sequence 0,1,1,1,1,1,1,1; pad_state=0x01.
REQ-028 Make {ext=1,0x74} and {0,0x5A}; joy=0x02 -> pad_state=0x8A; serial sequence 1,0,1,0,1,1,1,0; 9th and 10th pulses -> 1.
REQ-029 Make {ext=0,0x74} (ext mismatch) and unmapped 0x29 -> pad_state stays 0x00; a break of unheld Up -> stays 0x00.
REQ-030 Latch rise at cycle N -> famicom_data reflects bit0 after the 3rd edge; pulse edge coincident with latch=1 -> no shift; latch reasserted after 3 pulses -> output returns to A.
REQ-031 Reset after 4 pulses, with ps2_key[10]=1 held stable -> famicom_data=1, pad_state=0x00, no key event after release; the next latch reports current joy.
